// File: rtl/decoder_pkg.sv
// Shared types and helpers for the grant decoder.
// Holds the state encoding, the default hold length and the one-hot helper.
package decoder_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_DRIVE = 1'b1;

  localparam int HOLD_MAX_DEF = 15;

  typedef enum logic {
    IDLE  = ST_IDLE,
    DRIVE = ST_DRIVE
  } state_e;

  function automatic logic [7:0] onehot8(
    input logic [2:0] code
  );
    return 8'b1 << code;
  endfunction

endpackage

// File: rtl/code_pending_buf.sv
// One-entry holding slot for the next index.
// A write only happens while empty, so write and read never collide.
module code_pending_buf (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_code,
  input  logic       rd_en,
  output logic [2:0] rd_code,
  output logic       full
);

  logic       full_q;
  logic [2:0] code_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      code_q <= 3'd0;
    end else if (wr_en) begin
      full_q <= 1'b1;
      code_q <= wr_code;
    end else if (rd_en) begin
      full_q <= 1'b0;
    end
  end

  assign rd_code = code_q;
  assign full    = full_q;

endmodule

// File: rtl/grant_decoder_3to8.sv
// Sequential 3-to-8 grant decoder with hold timeout.
// A pending slot keeps back-to-back grants free of idle cycles.
module grant_decoder_3to8
  import decoder_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEF,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] in_code,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       ack,
  output logic [7:0] out,
  output logic       out_valid,
  output logic       timeout
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic               timeout_q, timeout_d;

  logic               pb_wr;
  logic               pb_rd;
  logic [2:0]         pb_code;
  logic               pb_full;

  logic               xfer;
  logic               last_cyc;
  logic               rel;

  code_pending_buf u_pend (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (pb_wr),
    .wr_code (in_code),
    .rd_en   (pb_rd),
    .rd_code (pb_code),
    .full    (pb_full)
  );

  assign in_ready = !pb_full;
  assign xfer     = in_valid && in_ready;
  assign last_cyc = (cnt_q == CNT_W'(HOLD_MAX - 1));
  assign rel      = ack || last_cyc;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    timeout_d   = 1'b0;
    pb_wr       = 1'b0;
    pb_rd       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          out_d       = onehot8(in_code);
          out_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = DRIVE;
        end
      end
      DRIVE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (rel) begin
          // ack wins over the hold limit on the final cycle
          timeout_d = !ack;
          unique case (1'b1)
            pb_full: begin
              out_d = onehot8(pb_code);
              cnt_d = '0;
              pb_rd = 1'b1;
            end
            xfer: begin
              out_d = onehot8(in_code);
              cnt_d = '0;
            end
            default: begin
              out_d       = 8'h00;
              out_valid_d = 1'b0;
              cnt_d       = '0;
              state_d     = IDLE;
            end
          endcase
        end else if (xfer) begin
          pb_wr = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_q       <= 8'h00;
      out_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_grant_decoder_3to8.sv
// Bench for grant_decoder_3to8: directed scenarios plus random traffic
// compared every cycle against a queue-based grant model.
module tb_grant_decoder_3to8;

  localparam int HOLD = 15;

  logic       clk;
  logic       rst;
  logic [2:0] in_code;
  logic       in_valid;
  logic       in_ready;
  logic       ack;
  logic [7:0] out;
  logic       out_valid;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  grant_decoder_3to8 #(
    .HOLD_MAX (HOLD),
    .CNT_W    (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_code   (in_code),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ack       (ack),
    .out       (out),
    .out_valid (out_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Model: a grant is "busy" with code m_cur for m_held finished cycles;
  // queued indices wait in m_pq (capacity one).
  bit         m_busy = 1'b0;
  logic [2:0] m_cur  = 3'd0;
  int         m_held = 0;
  logic [2:0] m_pq[$];
  bit         m_tmo  = 1'b0;

  always @(posedge clk or posedge rst) begin
    bit acc;
    if (rst) begin
      m_busy = 1'b0;
      m_held = 0;
      m_tmo  = 1'b0;
      m_pq.delete();
    end else begin
      acc   = in_valid && (m_pq.size() == 0);
      m_tmo = 1'b0;
      if (!m_busy) begin
        if (acc) begin
          m_busy = 1'b1;
          m_cur  = in_code;
          m_held = 0;
        end
      end else begin
        m_held++;
        if (ack || m_held == HOLD) begin
          m_tmo = !ack;
          if (m_pq.size() > 0) begin
            m_cur  = m_pq.pop_front();
            m_held = 0;
          end else if (acc) begin
            m_cur  = in_code;
            m_held = 0;
          end else begin
            m_busy = 1'b0;
          end
        end else if (acc) begin
          m_pq.push_back(in_code);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("cmp_out", 32'(out), m_busy ? 32'(1) << m_cur : 32'd0);
      chk("cmp_out_valid", 32'(out_valid), 32'(m_busy));
      chk("cmp_timeout", 32'(timeout), 32'(m_tmo));
      chk("cmp_in_ready", 32'(in_ready), 32'(m_pq.size() == 0));
    end
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_code  = 3'd0;
    ack      = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_out", 32'(out), 32'h00);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // code 5, ack in grant cycle 3
    in_code  = 3'd5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("a_c1", 32'(out), 32'h20);
    tick();
    chk("a_c2", 32'(out), 32'h20);
    tick();
    chk("a_c3", 32'(out), 32'h20);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("a_drop", 32'(out), 32'h00);
    chk("a_tmo", 32'(timeout), 32'd0);

    // code 0, never acked
    in_code  = 3'd0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < HOLD; i++) begin
      chk("b_hold", 32'(out), 32'h01);
      chk("b_no_tmo", 32'(timeout), 32'd0);
      tick();
    end
    chk("b_drop", 32'(out), 32'h00);
    chk("b_tmo", 32'(timeout), 32'd1);
    tick();
    chk("b_tmo_end", 32'(timeout), 32'd0);

    // 2, then 7 queued, then 4 stalled until the slot frees
    in_code  = 3'd2;
    in_valid = 1'b1;
    tick();
    in_code = 3'd7;
    tick();
    chk("c_out2", 32'(out), 32'h04);
    chk("c_rdy_lo", 32'(in_ready), 32'd0);
    in_code = 3'd4;
    ack     = 1'b1;
    tick();
    ack = 1'b0;
    chk("c_out7", 32'(out), 32'h80);
    chk("c_rdy_hi", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("c_rdy_lo2", 32'(in_ready), 32'd0);
    chk("c_out7b", 32'(out), 32'h80);
    ack = 1'b1;
    tick();
    chk("c_out4", 32'(out), 32'h10);
    tick();
    ack = 1'b0;
    chk("c_idle", 32'(out), 32'h00);

    // ack on the final hold cycle with a bypass index
    in_code  = 3'd1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (HOLD - 1) tick();
    chk("d_last", 32'(out), 32'h02);
    ack      = 1'b1;
    in_valid = 1'b1;
    in_code  = 3'd6;
    tick();
    ack      = 1'b0;
    in_valid = 1'b0;
    chk("d_byp", 32'(out), 32'h40);
    chk("d_no_tmo", 32'(timeout), 32'd0);
    repeat (HOLD) tick();
    chk("d_tmo", 32'(timeout), 32'd1);

    // ack in IDLE is ignored
    ack      = 1'b1;
    in_valid = 1'b1;
    in_code  = 3'd3;
    tick();
    in_valid = 1'b0;
    chk("e_out", 32'(out), 32'h08);
    tick();
    ack = 1'b0;
    chk("e_drop", 32'(out), 32'h00);

    // reset mid-grant with the slot full
    in_code  = 3'd2;
    in_valid = 1'b1;
    tick();
    in_code = 3'd5;
    tick();
    in_valid = 1'b0;
    chk("f_rdy_lo", 32'(in_ready), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("f_out", 32'(out), 32'h00);
    chk("f_ov", 32'(out_valid), 32'd0);
    chk("f_rdy", 32'(in_ready), 32'd1);
    tick();
    rst = 1'b0;
    repeat (5) begin
      tick();
      chk("f_discard", 32'(out), 32'h00);
      chk("f_tmo", 32'(timeout), 32'd0);
    end

    // random traffic, frequent then rare acks
    for (int ph = 0; ph < 2; ph++) begin
      repeat (1500) begin
        in_valid = 1'($urandom_range(0, 1));
        in_code  = 3'($urandom_range(0, 7));
        ack      = ($urandom_range(0, 99) < (ph == 0 ? 25 : 3));
        tick();
      end
    end
    in_valid = 1'b0;
    ack      = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
